// File: rtl/usb_host_bus_master.sv
// Host-side burst initiator for the 8-bit parallel USB register bus (address/data/rdn/wrn/cen cycles).
// Optional write-fetch timeout enabled by defining USB_HOST_BUS_MASTER_TIMEOUT_EN.
module usb_host_bus_master #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pSETUP        = 1,
    parameter int pWR_STROBE    = 2,
    parameter int pRD_WAIT      = 4
) (
    input  logic                   usb_clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]             cmd_len,
    input  logic [7:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic                   done,
    output logic                   rd_err,
`ifdef USB_HOST_BUS_MASTER_TIMEOUT_EN
    output logic                   wr_timeout,
`endif
    output logic [pADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]             bus_wdata,
    input  logic [7:0]             bus_rdata,
    input  logic                   bus_isout,
    output logic                   bus_rdn,
    output logic                   bus_wrn,
    output logic                   bus_cen,
    output logic                   bus_alen
);

    typedef enum logic [2:0] {IDLE, WFETCH, SETUP, WSTB, RSTB, HOLD, DONE} state_t;

    localparam int CNT_W = 8;
    localparam int BC    = pBYTECNT_SIZE;

    state_t           state, next_state;
    logic [CNT_W-1:0] phase_cnt;
    logic [7:0]       remain;
    logic             is_write;
    logic             setup_last, wstb_last, rstb_last, cmd_accept;
    logic             cen_d, rdn_d, wrn_d, wr_ready_d, done_d;

    assign bus_alen   = 1'b1;
    assign cmd_ready  = (state == IDLE);
    assign cmd_accept = (state == IDLE) && cmd_valid;
    assign setup_last = (phase_cnt == CNT_W'(pSETUP - 1));
    assign wstb_last  = (phase_cnt == CNT_W'(pWR_STROBE - 1));
    assign rstb_last  = (phase_cnt == CNT_W'(pRD_WAIT - 1));

`ifdef USB_HOST_BUS_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    // Abort as the wait count reaches 0xFFFF, i.e. after 65535 cycles without a byte.
    assign tmo_hit = (state == WFETCH) && !wr_valid && (tmo_cnt == 16'hFFFE);

    always_ff @(posedge usb_clk) begin
        if (rst || state != WFETCH || wr_valid) tmo_cnt <= 16'd0;
        else                                    tmo_cnt <= tmo_cnt + 16'd1;
    end

    always_ff @(posedge usb_clk) begin
        if (rst)             wr_timeout <= 1'b0;
        else if (cmd_accept) wr_timeout <= 1'b0;
        else if (tmo_hit)    wr_timeout <= 1'b1;
    end
`endif

    always_ff @(posedge usb_clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid) next_state = cmd_write ? WFETCH : SETUP;
            WFETCH: begin
                if (wr_valid) next_state = SETUP;
`ifdef USB_HOST_BUS_MASTER_TIMEOUT_EN
                else if (tmo_hit) next_state = DONE;
`endif
            end
            SETUP:   if (setup_last) next_state = is_write ? WSTB : RSTB;
            WSTB:    if (wstb_last) next_state = HOLD;
            RSTB:    if (rstb_last) next_state = HOLD;
            HOLD:    next_state = (remain == 8'd0) ? DONE : (is_write ? WFETCH : SETUP);
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so the registered pins line up with it.
    always_comb begin
        cen_d      = !(next_state inside {WFETCH, SETUP, WSTB, RSTB, HOLD});
        rdn_d      = (next_state != RSTB);
        wrn_d      = (next_state != WSTB);
        wr_ready_d = (next_state == WFETCH);
        done_d     = (next_state == DONE);
    end

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            bus_cen  <= 1'b1;
            bus_rdn  <= 1'b1;
            bus_wrn  <= 1'b1;
            wr_ready <= 1'b0;
            done     <= 1'b0;
        end else begin
            bus_cen  <= cen_d;
            bus_rdn  <= rdn_d;
            bus_wrn  <= wrn_d;
            wr_ready <= wr_ready_d;
            done     <= done_d;
        end
    end

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            bus_addr  <= '0;
            bus_wdata <= 8'd0;
            rd_data   <= 8'd0;
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            remain    <= 8'd0;
            is_write  <= 1'b0;
            phase_cnt <= '0;
        end else begin
            rd_valid  <= 1'b0;
            phase_cnt <= (next_state != state) ? '0 : phase_cnt + CNT_W'(1);
            case (state)
                IDLE: if (cmd_valid) begin
                    is_write <= cmd_write;
                    bus_addr <= cmd_addr;
                    remain   <= cmd_len;
                    rd_err   <= 1'b0;
                end
                WFETCH: if (wr_valid) bus_wdata <= wr_data;
                RSTB: if (rstb_last) begin
                    rd_data  <= bus_rdata;
                    rd_valid <= 1'b1;
                    if (!bus_isout) rd_err <= 1'b1;
                end
                // Burst addressing wraps inside the byte-count field only.
                HOLD: if (remain != 8'd0) begin
                    remain            <= remain - 8'd1;
                    bus_addr[BC-1:0]  <= bus_addr[BC-1:0] + BC'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_host_bus_master.sv
// Bench for usb_host_bus_master: directed and random bursts against an address/timing reference model.
module tb_usb_host_bus_master;

    localparam int AW  = 21;
    localparam int BCS = 7;
    localparam int PS  = 1;
    localparam int PW  = 2;
    localparam int PR  = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            len;
        logic          stable;
    } win_t;

    logic          usb_clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = 8'd0;
    logic [7:0]    wr_data = 8'd0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          done;
    logic          rd_err;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wdata;
    logic [7:0]    bus_rdata;
    logic          bus_isout = 1'b1;
    logic          bus_rdn, bus_wrn, bus_cen, bus_alen;
`ifdef USB_HOST_BUS_MASTER_TIMEOUT_EN
    logic          wr_timeout;
`endif

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor process)
    win_t       wq[$];
    win_t       rq[$];
    logic [7:0] vq[$];
    int         done_cnt = 0;
    int         prot_bad = 0;
    logic       in_w = 1'b0, in_r = 1'b0;
    win_t       cw, cr;

    always #5 usb_clk = ~usb_clk;

    // Target register model: reads return the low address byte.
    assign bus_rdata = bus_addr[7:0];

    usb_host_bus_master #(
        .pADDR_WIDTH(AW), .pBYTECNT_SIZE(BCS), .pSETUP(PS), .pWR_STROBE(PW), .pRD_WAIT(PR)
    ) dut (
        .usb_clk(usb_clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .rd_err(rd_err),
`ifdef USB_HOST_BUS_MASTER_TIMEOUT_EN
        .wr_timeout(wr_timeout),
`endif
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_isout(bus_isout), .bus_rdn(bus_rdn), .bus_wrn(bus_wrn),
        .bus_cen(bus_cen), .bus_alen(bus_alen)
    );

    always @(negedge usb_clk) begin
        if (rst) begin
            in_w <= 1'b0;
            in_r <= 1'b0;
        end else begin
            prot_bad <= prot_bad + int'(!bus_rdn && !bus_wrn) + int'((!bus_rdn || !bus_wrn) && bus_cen);
            if (!bus_wrn) begin
                if (!in_w) begin
                    in_w <= 1'b1;
                    cw   <= '{addr: bus_addr, data: bus_wdata, len: 1, stable: 1'b1};
                end else begin
                    cw.len    <= cw.len + 1;
                    cw.stable <= cw.stable && (bus_addr === cw.addr) && (bus_wdata === cw.data);
                end
            end else if (in_w) begin
                wq.push_back(cw);
                in_w <= 1'b0;
            end
            if (!bus_rdn) begin
                if (!in_r) begin
                    in_r <= 1'b1;
                    cr   <= '{addr: bus_addr, data: 8'd0, len: 1, stable: 1'b1};
                end else begin
                    cr.len    <= cr.len + 1;
                    cr.stable <= cr.stable && (bus_addr === cr.addr);
                end
            end else if (in_r) begin
                rq.push_back(cr);
                in_r <= 1'b0;
            end
            if (rd_valid) vq.push_back(rd_data);
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    // Reference: k-th byte address of a burst wraps inside the byte-count field.
    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int k);
        int unsigned b, span;
        b    = base;
        span = 1 << BCS;
        return AW'((b / span) * span + ((b % span) + k) % span);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge usb_clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [7:0] l);
        tick();
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        @(posedge usb_clk);
        #1;
        cmd_valid = 1'b0;
        check("rd_err_cleared", rd_err, 0);
`ifdef USB_HOST_BUS_MASTER_TIMEOUT_EN
        check("wr_timeout_cleared", wr_timeout, 0);
`endif
    endtask

    task automatic wait_done(input int d0, input int budget);
        int seen;
        seen = 0;
        for (int t = 0; t < budget; t++) begin
            tick();
            if (done_cnt > d0) begin seen = 1; break; end
        end
        check("done_seen", seen, 1);
        repeat (3) tick();
        check("done_once", done_cnt, d0 + 1);
        check("cmd_ready_after", cmd_ready, 1);
    endtask

    task automatic run_write(input logic [AW-1:0] a, input int len, input logic [7:0] first,
                             input int stall_idx, input int stall_cyc);
        logic [7:0] data[256];
        int w0, d0, ok;
        w0 = wq.size();
        d0 = done_cnt;
        for (int i = 0; i <= len; i++) data[i] = (i == 0) ? first : 8'($urandom);
        send_cmd(1'b1, a, 8'(len));
        for (int i = 0; i <= len; i++) begin
            if (i == stall_idx) begin
                ok = 0;
                for (int t = 0; t < 40; t++) begin
                    if (wr_ready) begin ok = 1; break; end
                    tick();
                end
                check("stall_reach_fetch", ok, 1);
                for (int s = 0; s < stall_cyc; s++) begin
                    tick();
                    check("stall_wrn_high", bus_wrn, 1);
                    check("stall_wr_ready", wr_ready, 1);
                end
            end
            wr_data  = data[i];
            wr_valid = 1'b1;
            ok = 0;
            for (int t = 0; t < 40; t++) begin
                if (wr_ready) begin ok = 1; break; end
                tick();
            end
            check("wr_accept", ok, 1);
            @(posedge usb_clk);
            #1;
            wr_valid = 1'b0;
        end
        wait_done(d0, 60);
        check("wr_windows", wq.size() - w0, len + 1);
        for (int i = 0; i <= len && (w0 + i) < wq.size(); i++) begin
            check("wr_addr", wq[w0 + i].addr, exp_addr(a, i));
            check("wr_data", wq[w0 + i].data, data[i]);
            check("wr_len", wq[w0 + i].len, PW);
            check("wr_stable", wq[w0 + i].stable, 1);
        end
    endtask

    task automatic run_read(input logic [AW-1:0] a, input int len, input logic isout);
        int r0, v0, d0, cyc, first;
        bus_isout = isout;
        r0 = rq.size(); v0 = vq.size(); d0 = done_cnt;
        first = 0;
        send_cmd(1'b0, a, 8'(len));
        cyc = 0;
        for (int t = 0; t < 2000; t++) begin
            tick();
            cyc++;
            if (first == 0 && vq.size() > v0) begin
                first = 1;
                check("rd_err_first", rd_err, !isout);
            end
            if (done_cnt > d0) break;
        end
        check("rd_burst_cycles", cyc, (len + 1) * (PS + PR + 1) + 1);
        repeat (3) tick();
        check("rd_done_once", done_cnt, d0 + 1);
        check("rd_err_sticky", rd_err, !isout);
        check("rd_windows", rq.size() - r0, len + 1);
        check("rd_values", vq.size() - v0, len + 1);
        for (int i = 0; i <= len && (r0 + i) < rq.size() && (v0 + i) < vq.size(); i++) begin
            check("rd_addr", rq[r0 + i].addr, exp_addr(a, i));
            check("rd_len", rq[r0 + i].len, PR);
            check("rd_data", vq[v0 + i], exp_addr(a, i) & 21'hFF);
        end
        bus_isout = 1'b1;
    endtask

    initial begin
        int d0, w0, ok;
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge usb_clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rdn", bus_rdn, 1);
        check("rst_wrn", bus_wrn, 1);
        check("rst_cen", bus_cen, 1);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("alen_tied", bus_alen, 1);
        rst = 1'b0;

        // Single write, burst read with wrap, stalled write, read with target not driving
        run_write(21'h00081, 0, 8'hA5, -1, 0);
        run_read(21'h0017E, 3, 1'b1);
        run_write(21'h00A3C, 2, 8'h3C, 1, 10);
        run_read(21'h00040, 2, 1'b0);
        run_write(21'h0007F, 1, 8'h11, -1, 0);

        // Reset in the middle of the first write strobe of a 4-byte burst
        d0 = done_cnt;
        send_cmd(1'b1, 21'h00300, 8'd3);
        wr_data = 8'h5A;
        wr_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (!bus_wrn) begin ok = 1; break; end
        end
        check("midrst_reach_wstb", ok, 1);
        rst = 1'b1;
        @(posedge usb_clk);
        #1;
        check("midrst_wrn", bus_wrn, 1);
        check("midrst_cen", bus_cen, 1);
        check("midrst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        wr_valid = 1'b0;
        repeat (20) tick();
        check("midrst_no_done", done_cnt, d0);

        // Randomized bursts
        for (int n = 0; n < 8; n++) begin
            logic [AW-1:0] a;
            int l;
            a = AW'($urandom);
            l = int'($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) run_write(a, l, 8'($urandom), -1, 0);
            else                           run_read(a, l, 1'b1);
        end

`ifdef USB_HOST_BUS_MASTER_TIMEOUT_EN
        // No write data ever offered: burst must time out without a write strobe
        w0 = wq.size();
        d0 = done_cnt;
        send_cmd(1'b1, 21'h00055, 8'd0);
        wr_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 70000; t++) begin
            tick();
            if (done_cnt > d0) begin ok = 1; break; end
        end
        check("tmo_done", ok, 1);
        check("tmo_flag", wr_timeout, 1);
        check("tmo_no_wrn", wq.size(), w0);
        run_read(21'h00010, 0, 1'b1);
`else
        w0 = 0;
`endif

        check("protocol_strobes", prot_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_host_bus_master.md
Name: usb_host_bus_master

Overview:
- Host-side initiator for the 8-bit parallel USB register bus; generates the address, data, rdn, wrn and cen cycles that the target register frontend decodes.
- Accepts burst commands (read/write, start address, length) on a valid/ready interface.
- Streams write bytes in and read bytes out.
- Used in simulation benches and in on-FPGA loopback/self-test of register blocks without the SAM3U.

Parameters:
- pADDR_WIDTH, 21, bus address width.
- pBYTECNT_SIZE, 7, width of byte-count field (low address bits); burst increments wrap inside this field.
- pSETUP, 1, cycles (>=1) address/data/cen driven before the strobe falls.
- pWR_STROBE, 2, cycles (>=1) wrn held low per write byte.
- pRD_WAIT, 4, cycles (>=3) rdn held low per read byte; bus_rdata sampled in the last of these.

Ports:
- usb_clk  in  1  bus clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  pADDR_WIDTH  start address.
- cmd_len  in  8  bytes minus one (0 = 1 byte, 255 = 256 bytes).
- wr_data  in  8  write byte.
- wr_valid  in  1  write byte available.
- wr_ready  out  1  write byte accepted when wr_valid&wr_ready.
- rd_data  out  8  captured read byte.
- rd_valid  out  1  one-cycle pulse per read byte.
- done  out  1  one-cycle pulse at burst end.
- rd_err  out  1  sticky; bus_isout low at a read sample point; cleared by next accepted command.
- bus_addr  out  pADDR_WIDTH  to target usb_addr.
- bus_wdata  out  8  to target usb_din.
- bus_rdata  in  8  from target usb_dout.
- bus_isout  in  1  target drive-enable.
- bus_rdn, bus_wrn, bus_cen  out  1 each  active-low strobes.
- bus_alen  out  1  tied 1 (unused).

Behaviour:
- Interface: reset rst, synchronous, active-high; clock usb_clk.
- All bus outputs are registered.
- Reset values:
  - bus_rdn=bus_wrn=bus_cen=1, bus_addr=0, bus_wdata=0.
  - rd_data=0, rd_valid=0, done=0, rd_err=0, wr_ready=0.
  - State IDLE, so cmd_ready=1 the first cycle after reset.
- Reset mid-burst: strobes return high on the next edge, the burst is abandoned, and no done pulse is issued.
- States: IDLE, WFETCH, SETUP, WSTB, RSTB, HOLD, DONE.
- IDLE: on cmd_valid, latch cmd_write, cmd_addr, cmd_len into a remaining-count register and clear rd_err. Next state: WFETCH if write, else SETUP.
- WFETCH: wr_ready=1, bus_cen=0. On wr_valid, bus_wdata<=wr_data, then SETUP. Stalls indefinitely while wr_valid=0, with strobes high.
- SETUP: bus_cen=0, bus_addr stable. Lasts pSETUP cycles, then WSTB or RSTB.
- WSTB: bus_wrn=0 for exactly pWR_STROBE cycles; bus_addr and bus_wdata are unchanged throughout.
- RSTB: bus_rdn=0 for pRD_WAIT cycles.
  - On the last cycle edge: rd_data<=bus_rdata and rd_valid=1 for the following cycle.
  - If bus_isout=0 at that edge, rd_err<=1.
- HOLD (1 cycle): strobes high, bus_cen=0, address and data held.
  - If remaining count = 0: DONE.
  - Otherwise: decrement the count and increment bus_addr[pBYTECNT_SIZE-1:0] modulo 2^pBYTECNT_SIZE; upper bits unchanged. Next state WFETCH (write) or SETUP (read).
- DONE (1 cycle): done=1, bus_cen<=1, then IDLE.
- Per-byte bus time:
  - Write: pSETUP+pWR_STROBE+1 cycles, plus the WFETCH cycles.
  - Read: pSETUP+pRD_WAIT+1 cycles.
- rdn and wrn are never low simultaneously, and never low while cen=1.
- cmd_valid outside IDLE is ignored (not latched).

Optional Feature:
- USB_HOST_BUS_MASTER_TIMEOUT_EN defined: a 16-bit counter runs while in WFETCH and is cleared on each accepted byte. At count 0xFFFF the burst aborts: strobes stay high, go to DONE, and sticky output wr_timeout=1 is set; it is cleared by the next accepted command.
- Not defined: no counter, the wr_timeout port is absent, and WFETCH waits forever.

Test Plan:
- Reset, then single write: cmd addr=0x00081, len=0, wr_data=0xA5 -> one wrn-low window of exactly 2 cycles, with bus_addr=0x00081 and bus_wdata=0xA5 stable throughout; done pulses once; cmd_ready returns to 1.
- 4-byte read from 0x0017E, target model returning addr[7:0] -> rd_valid pulses with rd_data 0x7E, 0x7F, 0x00, 0x01 (byte-count wrap, upper bits 0x0017E>>7 unchanged); rd_err=0.
- Write burst len=2 with wr_valid dropped for 10 cycles before byte 2 -> strobes held high during the stall; 3 write windows total, at addresses +0, +1, +2.
- Read with a target model holding bus_isout=0 -> rd_err=1 after the first sample, staying high until the next cmd accept.
- Assert rst in the middle of WSTB of byte 1 of a 4-byte write -> bus_wrn=1 and bus_cen=1 the next cycle, no done pulse, cmd_ready=1.
- Macro defined, wr_valid never asserted -> done and wr_timeout=1 after 65535 WFETCH cycles, with no wrn low pulse.
